// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phy_pkg
// Description : Symbols and state encoding shared by the PHY TX serializer and
//               the downstream serial-to-parallel / IDLE detector.
// Revision    : 1.0 - initial release
// ============================================================================
package phy_pkg;

    localparam logic [7:0] COM_SYM  = 8'hBC;
    localparam logic [7:0] IDLE_SYM = 8'h7C;

    typedef enum logic [0:0] {
        ST_COM    = 1'b0,
        ST_ACTIVE = 1'b1
    } phy_state_t;

endpackage : phy_pkg
`default_nettype wire

// File: rtl/paralelo_serial_phytx_if.sv
`default_nettype none
// ============================================================================
// Module      : paralelo_serial_phytx_if
// Description : Byte valid/ready handshake between upstream and the serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface paralelo_serial_phytx_if;

    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out
    );

endinterface : paralelo_serial_phytx_if
`default_nettype wire

// File: rtl/paralelo_serial_phytx_piso.sv
`default_nettype none
// ============================================================================
// Module      : piso_byte
// Description : 8-bit MSB-first shift register with its bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_byte (
    input  wire logic       clk_1,
    input  wire logic       reset,
    input  wire logic       load,
    input  wire logic [7:0] load_byte,
    output logic            sout,
    output logic            at_boundary,
    output logic            byte_start
);

    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;

    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            r_sr      <= 8'h00;
            r_bit_cnt <= 3'd7;
        end else begin
            r_sr      <= load ? load_byte : {r_sr[6:0], 1'b0};
            r_bit_cnt <= at_boundary ? 3'd0 : r_bit_cnt + 3'd1;
        end
    end

    assign sout        = r_sr[7];
    assign at_boundary = (r_bit_cnt == 3'd7);
    assign byte_start  = (r_bit_cnt == 3'd0);

endmodule : piso_byte
`default_nettype wire

// File: rtl/paralelo_serial_phytx.sv
`default_nettype none
// ============================================================================
// Module      : paralelo_serial_phytx
// Description : PHY TX serializer: COM burst after reset, then data bytes with
//               IDLE fill in every slot that upstream leaves empty.
// Revision    : 1.0 - initial release
// ============================================================================
module paralelo_serial_phytx #(
    parameter int         N_COM    = 4,
    parameter logic [7:0] COM_SYM  = phy_pkg::COM_SYM,
    parameter logic [7:0] IDLE_SYM = phy_pkg::IDLE_SYM
) (
    input  wire logic                  clk_1,
    input  wire logic                  reset,
    paralelo_serial_phytx_if.slave     up,
    output logic                       serial_out,
    output logic                       active_out,
    output logic                       idle_ins,
    output logic                       byte_start
);

    import phy_pkg::*;

    localparam int         CW         = $clog2(N_COM + 1);
    localparam logic [CW-1:0] C_COM_LAST = CW'(N_COM - 1);

    phy_state_t  r_state;
    phy_state_t  w_state_nxt;
    logic [CW-1:0] r_com_cnt;
    logic [CW-1:0] w_com_cnt_nxt;
    logic [7:0]  w_next_byte;
    logic        w_idle_load;
    logic        w_at_boundary;
    logic        r_active;
    logic        r_idle_ins;

    piso_byte u_piso (
        .clk_1       (clk_1),
        .reset       (reset),
        .load        (w_at_boundary),
        .load_byte   (w_next_byte),
        .sout        (serial_out),
        .at_boundary (w_at_boundary),
        .byte_start  (byte_start)
    );

    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_COM;
            r_com_cnt  <= '0;
            r_active   <= 1'b0;
            r_idle_ins <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_com_cnt  <= w_com_cnt_nxt;
            r_idle_ins <= w_idle_load;
            // Sampled only at byte loads so the flag rises with the first post-COM byte
            if (w_at_boundary) begin
                r_active <= (r_state == ST_ACTIVE);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_com_cnt_nxt = r_com_cnt;
        w_next_byte   = COM_SYM;
        w_idle_load   = 1'b0;
        case (r_state)
            ST_COM: begin
                w_next_byte = COM_SYM;
                if (w_at_boundary) begin
                    if (r_com_cnt == C_COM_LAST) begin
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_com_cnt_nxt = r_com_cnt + CW'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                w_next_byte = up.valid_in ? up.data_in : IDLE_SYM;
                w_idle_load = w_at_boundary && !up.valid_in;
            end
            default: begin
                w_state_nxt = ST_COM;
            end
        endcase
    end

    assign up.ready_out = (r_state == ST_ACTIVE) && w_at_boundary;
    assign active_out   = r_active;
    assign idle_ins     = r_idle_ins;

endmodule : paralelo_serial_phytx
`default_nettype wire

// File: tb/tb_paralelo_serial_phytx.sv
`default_nettype none
// ============================================================================
// Module      : tb_paralelo_serial_phytx
// Description : Scoreboard bench: stimulus queues expected bytes, a monitor
//               deserializes serial_out and compares byte, active and idle flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paralelo_serial_phytx;

    logic clk_1 = 1'b0;
    logic reset = 1'b0;
    logic serial_out, active_out, idle_ins, byte_start;

    always #5 clk_1 = ~clk_1;

    paralelo_serial_phytx_if up_if ();

    paralelo_serial_phytx #(.N_COM(4)) dut (
        .clk_1      (clk_1),
        .reset      (reset),
        .up         (up_if.slave),
        .serial_out (serial_out),
        .active_out (active_out),
        .idle_ins   (idle_ins),
        .byte_start (byte_start)
    );

    typedef struct {
        logic [7:0] b;
        logic       act;
        logic       idl;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void push(logic [7:0] b, logic act, logic idl);
        exp_t e;
        e.b = b; e.act = act; e.idl = idl;
        exp_q.push_back(e);
    endfunction

    function automatic void push_com_burst();
        for (int i = 0; i < 4; i++) push(8'hBC, 1'b0, 1'b0);
    endfunction

    // Monitor: rebuild each byte from byte_start and compare against the queue
    exp_t       cur;
    bit         cur_v    = 0;
    bit         chk_next = 0;
    int         nb       = 0;
    logic [7:0] sh       = 8'h00;

    always @(negedge clk_1) begin
        if (!reset) begin
            cur_v    = 0;
            chk_next = 0;
            nb       = 0;
        end else begin
            if (chk_next) begin
                chk_next = 0;
                check("byte_contiguous", {31'd0, byte_start}, 32'd1);
            end
            if (byte_start) begin
                nb = 0;
                sh = 8'h00;
                if (exp_q.size() > 0) begin
                    cur   = exp_q.pop_front();
                    cur_v = 1;
                    check("active_out", {31'd0, active_out}, {31'd0, cur.act});
                    check("idle_ins",   {31'd0, idle_ins},   {31'd0, cur.idl});
                end else begin
                    cur_v = 0;
                end
            end
            if (cur_v) begin
                sh = {sh[6:0], serial_out};
                nb++;
                if (nb == 8) begin
                    check("serial_byte", {24'd0, sh}, {24'd0, cur.b});
                    n_done++;
                    cur_v    = 0;
                    chk_next = 1;
                end
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk_1);
        #1;
    endtask

    task automatic assert_reset();
        reset          = 1'b0;
        up_if.valid_in = 1'b0;
        up_if.data_in  = 8'h00;
        exp_q.delete();
        n_done = 0;
    endtask

    task automatic release_reset();
        wait_edges(2);
        check("rst_serial_out", {31'd0, serial_out},      32'd0);
        check("rst_ready_out",  {31'd0, up_if.ready_out}, 32'd0);
        check("rst_flags", {29'd0, active_out, idle_ins, byte_start}, 32'd0);
        reset = 1'b1;
        @(negedge clk_1);
        check("first_cycle_serial", {31'd0, serial_out}, 32'd0);
        check("first_cycle_start",  {31'd0, byte_start}, 32'd0);
    endtask

    task automatic wait_done(input int n);
        int cyc = 0;
        while (n_done < n && cyc < 400) begin
            @(posedge clk_1);
            cyc++;
        end
        #1;
        check("bytes_seen", n_done, n);
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (!up_if.ready_out && k < 100) begin
            @(posedge clk_1);
            #1;
            k++;
        end
    endtask

    initial begin
        int k;
        int rc;
        int idx;
        logic [7:0] b2b [3];

        // 1: COM burst then IDLE fill
        assert_reset();
        push_com_burst();
        for (int i = 0; i < 3; i++) push(8'h7C, 1'b1, 1'b1);
        release_reset();
        wait_done(7);

        // 2: data held from reset, first accept at the first ACTIVE boundary
        assert_reset();
        up_if.valid_in = 1'b1;
        up_if.data_in  = 8'hA5;
        push_com_burst();
        push(8'hA5, 1'b1, 1'b0);
        push(8'h7C, 1'b1, 1'b1);
        release_reset();
        wait_ready(k);
        check("first_ready_edge", k, 32);
        wait_edges(1);
        up_if.valid_in = 1'b0;
        wait_done(6);

        // 3: valid pulse while ready low is ignored; held valid is taken
        assert_reset();
        push_com_burst();
        push(8'h7C, 1'b1, 1'b1);
        push(8'h7C, 1'b1, 1'b1);
        push(8'h3C, 1'b1, 1'b0);
        push(8'h7C, 1'b1, 1'b1);
        release_reset();
        wait_edges(35);
        up_if.data_in  = 8'h3C;
        up_if.valid_in = 1'b1;
        check("pulse_ready_low", {31'd0, up_if.ready_out}, 32'd0);
        wait_edges(1);
        up_if.valid_in = 1'b0;
        wait_edges(6);
        up_if.valid_in = 1'b1;
        wait_ready(k);
        check("held_ready_wait", k, 6);
        wait_edges(1);
        up_if.valid_in = 1'b0;
        wait_done(8);

        // 4: back-to-back 01, FF, 7C
        assert_reset();
        b2b[0] = 8'h01; b2b[1] = 8'hFF; b2b[2] = 8'h7C;
        up_if.data_in  = b2b[0];
        up_if.valid_in = 1'b1;
        push_com_burst();
        for (int i = 0; i < 3; i++) push(b2b[i], 1'b1, 1'b0);
        push(8'h7C, 1'b1, 1'b1);
        release_reset();
        wait_ready(k);
        rc  = 0;
        idx = 0;
        for (int i = 0; i < 24; i++) begin
            automatic bit taken = up_if.ready_out && up_if.valid_in;
            if (up_if.ready_out) rc++;
            wait_edges(1);
            if (taken) begin
                idx++;
                if (idx < 3) up_if.data_in = b2b[idx];
                else         up_if.valid_in = 1'b0;
            end
        end
        check("ready_per_24", rc, 3);
        wait_done(8);

        // 5: reset at bit 3 of a data byte, then a fresh burst
        assert_reset();
        up_if.data_in  = 8'h5A;
        up_if.valid_in = 1'b1;
        push_com_burst();
        push(8'h5A, 1'b1, 1'b0);
        release_reset();
        wait_ready(k);
        wait_edges(1);
        up_if.valid_in = 1'b0;
        wait_edges(4);
        check("bit3_before_reset", {31'd0, serial_out}, 32'd1);
        check("coms_before_reset", n_done, 4);
        assert_reset();
        #1;
        check("reset_serial_now", {31'd0, serial_out}, 32'd0);
        check("reset_active_now", {31'd0, active_out}, 32'd0);
        push_com_burst();
        push(8'h7C, 1'b1, 1'b1);
        release_reset();
        wait_done(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_paralelo_serial_phytx
`default_nettype wire
